// File: rtl/data_sram_req_ctrl.sv
// Data-memory request sequencer between the EXE/MEM pipeline and an SRAM-like req/addr_ok/data_ok bus.
// Optional misaligned-access trap: define DATA_SRAM_ALE_CHECK_EN to add the ale_ex/ale_badv outputs.
module data_sram_req_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_req_valid,
    input  logic        es_req_wr,
    input  logic [1:0]  es_req_size,
    input  logic [31:0] es_req_addr,
    input  logic [31:0] es_req_wdata,
    output logic        es_req_ready,
    output logic        ms_resp_valid,
    output logic [31:0] ms_resp_rdata,
    input  logic        ms_resp_ready,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        busy
`ifdef DATA_SRAM_ALE_CHECK_EN
    ,
    output logic        ale_ex,
    output logic [31:0] ale_badv
`endif
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]    MAX_C    = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state_q, state_d;
    logic        hold_sq_q, hold_sq_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [2:0]  inflight_q, inflight_d;
    logic [2:0]  discard_q, discard_d;
    logic [MAX_OUTSTANDING-1:0] wrq_q, wrq_d;

    logic [31:0]   fifo_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]    fifo_cnt_q, fifo_cnt_d;

    logic [3:0]  total;
    logic        accept, misalign, issue;
    logic        addr_hs, ack_inflight, ack_discard, done_inflight, done_discard;
    logic        push, pop;
    logic [31:0] push_data;
    logic [3:0]  strb_in;
    logic [31:0] wdata_in;
    logic [1:0]  size_in;
    logic [2:0]  cnt_tmp;

    assign total = {1'b0, inflight_q} + {1'b0, discard_q} + {1'b0, fifo_cnt_q};
    assign es_req_ready = !reset && (state_q == IDLE) && !flush && (total < MAX_C);
    assign accept = es_req_valid && es_req_ready;

`ifdef DATA_SRAM_ALE_CHECK_EN
    assign misalign = ((es_req_size == 2'd1) && es_req_addr[0]) ||
                      (es_req_size[1] && (es_req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign issue = accept && !misalign;

    always_comb begin
        size_in = es_req_size;
        case (es_req_size)
            2'd0: begin
                strb_in  = 4'b0001 << es_req_addr[1:0];
                wdata_in = {4{es_req_wdata[7:0]}};
            end
            2'd1: begin
                strb_in  = 4'b0011 << {es_req_addr[1], 1'b0};
                wdata_in = {2{es_req_wdata[15:0]}};
            end
            default: begin
                strb_in  = 4'b1111;
                wdata_in = es_req_wdata;
                size_in  = 2'd2;
            end
        endcase
        if (!es_req_wr) strb_in = '0;
    end

    always_comb begin
        state_d   = state_q;
        hold_sq_d = hold_sq_q;
        case (state_q)
            IDLE: begin
                hold_sq_d = 1'b0;
                if (issue) state_d = REQ;
            end
            REQ: begin
                if (data_sram_addr_ok) begin
                    state_d   = IDLE;
                    hold_sq_d = 1'b0;
                end else if (flush) begin
                    hold_sq_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses return in issue order and squashed ones are always the oldest,
    // so discard_count is drained before any live in-flight access.
    assign addr_hs       = (state_q == REQ) && data_sram_addr_ok;
    assign ack_inflight  = addr_hs && !hold_sq_q && !flush;
    assign ack_discard   = addr_hs && (hold_sq_q || flush);
    assign done_discard  = data_sram_data_ok && (discard_q != 3'd0);
    assign done_inflight = data_sram_data_ok && (discard_q == 3'd0);

    always_comb begin
        wrq_d   = wrq_q;
        cnt_tmp = inflight_q;
        if (flush) begin
            inflight_d = '0;
            discard_d  = discard_q + inflight_q - 3'(data_sram_data_ok) + 3'(ack_discard);
            wrq_d      = '0;
        end else begin
            inflight_d = inflight_q + 3'(ack_inflight) - 3'(done_inflight);
            discard_d  = discard_q + 3'(ack_discard) - 3'(done_discard);
            if (done_inflight) begin
                wrq_d   = wrq_q >> 1;
                cnt_tmp = inflight_q - 3'd1;
            end
            if (ack_inflight) begin
                for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (3'(i) == cnt_tmp) wrq_d[i] = wr_q;
                end
            end
        end
    end

    assign push      = done_inflight && !flush;
    assign pop       = ms_resp_valid && ms_resp_ready && !flush;
    assign push_data = wrq_q[0] ? '0 : data_sram_rdata;

    always_comb begin
        if (flush) begin
            fifo_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
            rd_ptr_d   = rd_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_sq_q  <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            wrq_q      <= '0;
            fifo_mem_q <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_sq_q  <= hold_sq_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            wrq_q      <= wrq_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (issue) begin
                wr_q    <= es_req_wr;
                size_q  <= size_in;
                addr_q  <= es_req_addr;
                wdata_q <= wdata_in;
                wstrb_q <= strb_in;
            end
            if (push) fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef DATA_SRAM_ALE_CHECK_EN
    logic        ale_ex_q;
    logic [31:0] ale_badv_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ale_ex_q   <= 1'b0;
            ale_badv_q <= '0;
        end else begin
            ale_ex_q <= accept && misalign;
            if (accept && misalign) ale_badv_q <= es_req_addr;
        end
    end

    assign ale_ex   = ale_ex_q;
    assign ale_badv = ale_badv_q;
`endif

    assign data_sram_req   = (state_q == REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;

    assign ms_resp_valid = (fifo_cnt_q != 3'd0);
    assign ms_resp_rdata = fifo_mem_q[rd_ptr_q];

    assign busy = (state_q == REQ) || (inflight_q != 3'd0) || (discard_q != 3'd0) || ms_resp_valid;

endmodule

// File: tb/tb_data_sram_req_ctrl.sv
// Directed bench for data_sram_req_ctrl; the bus side is driven by hand, one scenario per block.
module tb_data_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_req_valid, es_req_wr;
    logic [1:0]  es_req_size;
    logic [31:0] es_req_addr, es_req_wdata;
    logic        es_req_ready;
    logic        ms_resp_valid;
    logic [31:0] ms_resp_rdata;
    logic        ms_resp_ready;
    logic        flush;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        busy;
`ifdef DATA_SRAM_ALE_CHECK_EN
    logic        ale_ex;
    logic [31:0] ale_badv;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_req_valid      (es_req_valid),
        .es_req_wr         (es_req_wr),
        .es_req_size       (es_req_size),
        .es_req_addr       (es_req_addr),
        .es_req_wdata      (es_req_wdata),
        .es_req_ready      (es_req_ready),
        .ms_resp_valid     (ms_resp_valid),
        .ms_resp_rdata     (ms_resp_rdata),
        .ms_resp_ready     (ms_resp_ready),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .busy              (busy)
`ifdef DATA_SRAM_ALE_CHECK_EN
        ,
        .ale_ex            (ale_ex),
        .ale_badv          (ale_badv)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request, checks the bus payload, then completes the address handshake.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        es_req_valid = 1'b1;
        es_req_wr    = wr;
        es_req_size  = sz;
        es_req_addr  = a;
        es_req_wdata = d;
        #1 check("send_ready", 32'(es_req_ready), 32'd1);
        @(negedge clk);
        es_req_valid = 1'b0;
        #1;
        check("send_req", 32'(data_sram_req), 32'd1);
        check("send_addr", data_sram_addr, a);
        check("send_wr", 32'(data_sram_wr), 32'(wr));
        check("send_wstrb", 32'(data_sram_wstrb), 32'(exp_strb));
        if (wr) check("send_wdata", data_sram_wdata, exp_wd);
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
    endtask

    task automatic resp(input logic [31:0] rd);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        #1;
        check({tag, "_valid"}, 32'(ms_resp_valid), 32'd1);
        check({tag, "_data"}, ms_resp_rdata, exp);
        ms_resp_ready = 1'b1;
        @(negedge clk);
        ms_resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        es_req_valid = 1'b0; es_req_wr = 1'b0; es_req_size = 2'd0;
        es_req_addr = '0; es_req_wdata = '0;
        ms_resp_ready = 1'b0; flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(es_req_ready), 32'd0);
        check("rst_valid", 32'(ms_resp_valid), 32'd0);
        check("rst_req", 32'(data_sram_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("idle_ready", 32'(es_req_ready), 32'd1);

        // load word, data_ok two cycles after the address handshake
        send(1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'b0000, 32'h0);
        check("lw_busy", 32'(busy), 32'd1);
        @(negedge clk);
        resp(32'hDEAD_BEEF);
        pop_check("lw", 32'hDEAD_BEEF);
        #1;
        check("lw_once", 32'(ms_resp_valid), 32'd0);
        check("lw_idle", 32'(busy), 32'd0);

        // store byte / store half lane replication; stores return 0
        send(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        resp(32'h1111_2222);
        pop_check("sb", 32'h0);
        send(1'b1, 2'd1, 32'h0000_1002, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        resp(32'h3333_4444);
        pop_check("sh", 32'h0);

        // addr_ok held low: payload stable while EXE presents something else
        es_req_valid = 1'b1; es_req_wr = 1'b1; es_req_size = 2'd2;
        es_req_addr = 32'h0000_2004; es_req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        es_req_addr = 32'h9999_0000; es_req_wdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_req", 32'(data_sram_req), 32'd1);
            check("hold_addr", data_sram_addr, 32'h0000_2004);
            check("hold_wdata", data_sram_wdata, 32'hCAFE_F00D);
            check("hold_wstrb", 32'(data_sram_wstrb), 32'hF);
            check("hold_ready", 32'(es_req_ready), 32'd0);
            @(negedge clk);
        end
        es_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        resp(32'hFFFF_FFFF);
        pop_check("sw", 32'h0);

        // outstanding limit and response ordering
        send(1'b0, 2'd2, 32'h0000_3000, 32'h0, 4'b0000, 32'h0);
        send(1'b0, 2'd2, 32'h0000_3004, 32'h0, 4'b0000, 32'h0);
        es_req_valid = 1'b1; es_req_wr = 1'b0; es_req_addr = 32'h0000_3008;
        #1 check("lim_ready0", 32'(es_req_ready), 32'd0);
        resp(32'h1111_1111);
        #1 check("lim_ready1", 32'(es_req_ready), 32'd0);
        resp(32'h2222_2222);
        #1 check("lim_ready2", 32'(es_req_ready), 32'd0);
        pop_check("ord0", 32'h1111_1111);
        #1 check("lim_ready3", 32'(es_req_ready), 32'd1);
        @(negedge clk);
        es_req_valid = 1'b0;
        #1 check("lim_c_addr", data_sram_addr, 32'h0000_3008);
        data_sram_addr_ok = 1'b1;
        pop_check("ord1", 32'h2222_2222);
        data_sram_addr_ok = 1'b0;
        resp(32'h3333_3333);
        pop_check("ord2", 32'h3333_3333);

        // flush with two loads in flight
        send(1'b0, 2'd2, 32'h0000_4000, 32'h0, 4'b0000, 32'h0);
        send(1'b0, 2'd2, 32'h0000_4004, 32'h0, 4'b0000, 32'h0);
        flush = 1'b1;
        #1 check("fl_ready", 32'(es_req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy", 32'(busy), 32'd1);
        check("fl_ready2", 32'(es_req_ready), 32'd0);
        resp(32'hBAD0_0001);
        #1 check("fl_drop1", 32'(ms_resp_valid), 32'd0);
        resp(32'hBAD0_0002);
        #1;
        check("fl_drop2", 32'(ms_resp_valid), 32'd0);
        check("fl_idle", 32'(busy), 32'd0);
        send(1'b0, 2'd2, 32'h0000_4008, 32'h0, 4'b0000, 32'h0);
        resp(32'h600D_0003);
        pop_check("fl_next", 32'h600D_0003);

        // flush while holding a request: req stays up, its data is dropped
        es_req_valid = 1'b1; es_req_wr = 1'b0; es_req_size = 2'd2; es_req_addr = 32'h0000_5000;
        @(negedge clk);
        es_req_valid = 1'b0;
        flush = 1'b1;
        #1 check("fr_req0", 32'(data_sram_req), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fr_req1", 32'(data_sram_req), 32'd1);
        check("fr_addr", data_sram_addr, 32'h0000_5000);
        @(negedge clk);
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        #1;
        check("fr_req2", 32'(data_sram_req), 32'd0);
        check("fr_busy", 32'(busy), 32'd1);
        resp(32'hBAD0_0005);
        #1;
        check("fr_drop", 32'(ms_resp_valid), 32'd0);
        check("fr_idle", 32'(busy), 32'd0);
        send(1'b0, 2'd2, 32'h0000_5004, 32'h0, 4'b0000, 32'h0);
        resp(32'h7777_7777);
        pop_check("fr_next", 32'h7777_7777);

        // data_ok in the same cycle as flush is dropped against the old in-flight count
        send(1'b0, 2'd2, 32'h0000_6000, 32'h0, 4'b0000, 32'h0);
        send(1'b0, 2'd2, 32'h0000_6004, 32'h0, 4'b0000, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_0006; flush = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b0; flush = 1'b0;
        #1;
        check("df_valid", 32'(ms_resp_valid), 32'd0);
        check("df_busy", 32'(busy), 32'd1);
        resp(32'hBAD0_0007);
        #1;
        check("df_valid2", 32'(ms_resp_valid), 32'd0);
        check("df_idle", 32'(busy), 32'd0);
        send(1'b0, 2'd2, 32'h0000_6008, 32'h0, 4'b0000, 32'h0);
        resp(32'h8888_8888);
        pop_check("df_next", 32'h8888_8888);

        // addr_ok and data_ok in the same cycle
        send(1'b0, 2'd2, 32'h0000_7000, 32'h0, 4'b0000, 32'h0);
        es_req_valid = 1'b1; es_req_addr = 32'h0000_7004;
        @(negedge clk);
        es_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_00A1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        pop_check("ad_first", 32'h0000_00A1);
        resp(32'h0000_00A2);
        pop_check("ad_second", 32'h0000_00A2);
        #1 check("ad_idle", 32'(busy), 32'd0);

`ifdef DATA_SRAM_ALE_CHECK_EN
        es_req_valid = 1'b1; es_req_wr = 1'b0; es_req_size = 2'd1; es_req_addr = 32'h0000_1001;
        @(negedge clk);
        es_req_valid = 1'b0;
        #1;
        check("ale_ex", 32'(ale_ex), 32'd1);
        check("ale_badv", ale_badv, 32'h0000_1001);
        check("ale_noreq", 32'(data_sram_req), 32'd0);
        @(negedge clk);
        #1 check("ale_pulse", 32'(ale_ex), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
